pipe_skid_stage: RTL
====================

Name: pipe_skid_stage

Overview:
- Parametrised pipeline-boundary register with a valid/ready handshake and a 2-entry skid buffer. It is the successor to the fixed-field stage latches between MEM and WB.
- Carries an opaque payload of DATA_W bits, with per-instance selection of which stall-vector bits freeze it.
- Supports exception flush and a saturating hold-cycle counter for performance debug.
- Any pipeline boundary (IF/ID, ID/EX, EX/MEM, MEM/WB) instantiates it.

Parameters:
- DATA_W, 174, payload width in bits (default is the full MEM/WB bundle width).
- STALL_W, 4, width of the stall vector.
- STALL_MASK, 4'b1100, stall bits that freeze this stage (default: data_stall and exe_stall).
- FLUSH_CLEARS_DATA, 1, when 1, flush zeroes both data registers; when 0, data registers keep their values.
- CNT_W, 32, width of the hold counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-low.
- flush  in  1  exception flush, synchronous, active-high.
- stall  in  STALL_W  global stall vector.
- in_valid  in  1  upstream payload valid.
- in_ready  out  1  stage can accept; registered output.
- in_data  in  DATA_W  upstream payload.
- out_valid  out  1  main register holds a valid payload; registered.
- out_ready  in  1  downstream can accept.
- out_data  out  DATA_W  main register payload; registered.
- level  out  2  occupancy: 0, 1 or 2.
- hold_cycles  out  CNT_W  saturating count of held cycles.

Behaviour:
- Clock and reset: one clock domain, clk. Reset rst is asynchronous and active-low.
- While rst=0: out_valid=0, out_data=0, skid register=0, skid_valid=0, in_ready=1, level=0, hold_cycles=0. State is EMPTY.
- Derived signals:
  - stall_hit = |(stall & STALL_MASK)
  - hold = stall_hit | ~out_ready
  - in_fire = in_valid & in_ready
  - out_fire = out_valid & ~hold
- in_ready = ~skid_valid, registered. It is never a combinational function of out_ready or stall.
- Latency: 1 cycle from in_fire to out_valid. Sustained throughput is 1 per cycle when hold=0.
- State machine, encoded as {main_valid, skid_valid}:
  - EMPTY:
    - in_fire → main<=in_data, go to HALF.
    - otherwise stay in EMPTY.
  - HALF:
    - out_fire & in_fire → main<=in_data, stay in HALF.
    - out_fire & ~in_fire → go to EMPTY; main data is retained but invalid.
    - ~out_fire & in_fire → skid<=in_data, go to FULL.
    - otherwise stay in HALF.
  - FULL (in_ready=0):
    - out_fire → main<=skid, skid_valid<=0, go to HALF.
    - otherwise stay in FULL with both registers frozen.
- Ordering is strictly FIFO: the skid entry always exits after the main entry. No payload is ever dropped or duplicated except on flush.
- Flush:
  - Priority: reset > flush > stall/handshake.
  - Next state is EMPTY; in_ready becomes 1.
  - An in_fire in the flush cycle is discarded.
  - If FLUSH_CLEARS_DATA=1, main and skid data become 0.
  - hold_cycles is not affected.
- Stall vector bits outside STALL_MASK have no effect.
- A stall_hit with out_valid=0 freezes nothing. The stage still accepts input into main.
- hold_cycles: increments when out_valid & hold & ~flush. It saturates at all-ones and never wraps. Only reset clears it.
- level = main_valid + skid_valid, registered alongside the state.
- Reset asserted mid-operation (any state): outputs take their reset values immediately, independent of clk.

Decomposition:
- Shared defines header entries:
  - State encodings (EMPTY=2'b00, HALF=2'b10, FULL=2'b11).
  - Per-boundary STALL_MASK constants (IF_ID, ID_EX, EX_MEM, MEM_WB).
  - Payload width constants per boundary bundle.
- One sub-module: pipe_sat_counter (CNT_W parameter, inc input, async active-low reset) for hold_cycles.
- Payload packing/unpacking stays at the instantiation site.

Test Plan:
- Streaming: out_ready=1, stall=0, in_valid=1, payloads 0x1,0x2,0x3 on consecutive cycles → out_data shows 0x1,0x2,0x3 one cycle later, back-to-back. in_ready stays 1, level stays 1, hold_cycles=0.
- Masked stall with skid: A resident, stall=4'b1000 for 3 cycles, B,C offered.
  - B is captured to skid; in_ready=0 from the next cycle; C is held upstream; level=2.
  - After release: out shows A, B, C in order with no loss.
  - hold_cycles=3.
- Unmasked bits: stall=4'b0011 held 5 cycles while streaming → identical output to the streaming case; hold_cycles=0.
- Flush in FULL with in_valid=1 (payload 0xF) → next cycle out_valid=0, out_data=0, level=0, in_ready=1. 0xF never appears; hold_cycles unchanged.
- Saturation: CNT_W=4, out_valid=1, out_ready=0 for 20 cycles → hold_cycles reaches 15 and stays 15.
- Async reset mid-FULL: drop rst between clock edges → out_valid=0, level=0, in_ready=1 before the next edge. Normal streaming resumes after release.

Source files
------------

// File: rtl/pipe_skid_stage_pkg.sv
// -----------------------------------------------------------------------------
// pipe_skid_stage_pkg
// Shared definitions for the pipeline-boundary skid stage:
//   - skid_state_t : state encoding {main_valid, skid_valid}
//   - STALL_MASK_* : which stall-vector bits freeze each pipeline boundary
//                    (bit 3 = data_stall, bit 2 = exe_stall,
//                     bit 1 = id_stall,   bit 0 = if_stall)
//   - *_DATA_W     : payload bundle width for each boundary
//   - state_level  : occupancy (0..2) of a given state
// -----------------------------------------------------------------------------
package pipe_skid_stage_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_HALF  = 2'b10,
    ST_FULL  = 2'b11
  } skid_state_t;

  localparam logic [3:0] STALL_MASK_IF_ID  = 4'b1111;
  localparam logic [3:0] STALL_MASK_ID_EX  = 4'b1110;
  localparam logic [3:0] STALL_MASK_EX_MEM = 4'b1100;
  localparam logic [3:0] STALL_MASK_MEM_WB = 4'b1100;

  localparam int IF_ID_DATA_W  = 64;
  localparam int ID_EX_DATA_W  = 192;
  localparam int EX_MEM_DATA_W = 160;
  localparam int MEM_WB_DATA_W = 174;

  // The state encoding is {main_valid, skid_valid}, so occupancy is the
  // sum of its two bits.
  function automatic logic [1:0] state_level(input skid_state_t s);
    return {1'b0, s[1]} + {1'b0, s[0]};
  endfunction

endpackage

// File: rtl/pipe_skid_stage_sat_counter.sv
// -----------------------------------------------------------------------------
// pipe_sat_counter
// Saturating up-counter. Counts cycles where i_inc is high, sticks at
// all-ones instead of wrapping. Only reset clears it.
// Ports:
//   clk      in   clock, rising edge
//   rst_n    in   asynchronous active-low reset
//   i_inc    in   increment enable
//   o_count  out  current count (CNT_W bits)
// -----------------------------------------------------------------------------
module pipe_sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_inc,
  output logic [CNT_W-1:0] o_count
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic [CNT_W-1:0] r_count;
  logic             w_saturated;

  assign w_saturated = &r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_inc && !w_saturated) begin
      r_count <= r_count + ONE;
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/pipe_skid_stage.sv
// -----------------------------------------------------------------------------
// pipe_skid_stage
// Pipeline-boundary register with valid/ready handshake and a 2-entry skid
// buffer (main + skid). in_ready is registered and depends only on whether
// the skid entry is occupied, so no combinational path runs from downstream
// ready/stall back upstream. Supports exception flush and a saturating
// hold-cycle counter.
// Ports:
//   clk            in   clock, rising edge
//   rst_n          in   asynchronous active-low reset
//   i_flush        in   synchronous exception flush (active-high)
//   i_stall        in   global stall vector (STALL_W)
//   i_in_valid     in   upstream payload valid
//   o_in_ready     out  stage can accept (registered)
//   i_in_data      in   upstream payload (DATA_W)
//   o_out_valid    out  main register holds a valid payload (registered)
//   i_out_ready    in   downstream can accept
//   o_out_data     out  main register payload (DATA_W, registered)
//   o_level        out  occupancy 0..2 (registered)
//   o_hold_cycles  out  saturating count of held cycles (CNT_W)
// -----------------------------------------------------------------------------
module pipe_skid_stage
  import pipe_skid_stage_pkg::*;
#(
  parameter int                 DATA_W            = MEM_WB_DATA_W,
  parameter int                 STALL_W           = 4,
  parameter logic [STALL_W-1:0] STALL_MASK        = STALL_MASK_MEM_WB,
  parameter bit                 FLUSH_CLEARS_DATA = 1'b1,
  parameter int                 CNT_W             = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_flush,
  input  logic [STALL_W-1:0] i_stall,
  input  logic               i_in_valid,
  output logic               o_in_ready,
  input  logic [DATA_W-1:0]  i_in_data,
  output logic               o_out_valid,
  input  logic               i_out_ready,
  output logic [DATA_W-1:0]  o_out_data,
  output logic [1:0]         o_level,
  output logic [CNT_W-1:0]   o_hold_cycles
);

  skid_state_t       r_state;
  skid_state_t       w_next_state;
  logic              r_in_ready;
  logic [1:0]        r_level;
  logic [DATA_W-1:0] r_main_data;
  logic [DATA_W-1:0] r_skid_data;

  logic w_main_valid;
  logic w_stall_hit;
  logic w_hold;
  logic w_in_fire;
  logic w_out_fire;
  logic w_load_main_in;
  logic w_load_main_skid;
  logic w_load_skid;

  assign w_main_valid = r_state[1];

  // Only the stall bits selected for this boundary can freeze it.
  assign w_stall_hit = |(i_stall & STALL_MASK);
  assign w_hold      = w_stall_hit | ~i_out_ready;
  assign w_in_fire   = i_in_valid & r_in_ready;
  assign w_out_fire  = w_main_valid & ~w_hold;

  // Next-state and data-steering decode. Flush overrides any handshake,
  // so an in_fire in the flush cycle is simply dropped. In FULL, in_ready
  // is already low, so no upstream transfer can coincide.
  always_comb begin
    w_next_state     = r_state;
    w_load_main_in   = 1'b0;
    w_load_main_skid = 1'b0;
    w_load_skid      = 1'b0;
    if (i_flush) begin
      w_next_state = ST_EMPTY;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_in_fire) begin
            w_load_main_in = 1'b1;
            w_next_state   = ST_HALF;
          end
        end
        ST_HALF: begin
          if (w_out_fire && w_in_fire) begin
            w_load_main_in = 1'b1;
          end else if (w_out_fire) begin
            w_next_state = ST_EMPTY;
          end else if (w_in_fire) begin
            w_load_skid  = 1'b1;
            w_next_state = ST_FULL;
          end
        end
        ST_FULL: begin
          if (w_out_fire) begin
            w_load_main_skid = 1'b1;
            w_next_state     = ST_HALF;
          end
        end
        default: begin
          w_next_state = ST_EMPTY;
        end
      endcase
    end
  end

  // in_ready and level are registered copies derived from the next state,
  // so they always agree with r_state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_EMPTY;
      r_in_ready <= 1'b1;
      r_level    <= 2'd0;
    end else begin
      r_state    <= w_next_state;
      r_in_ready <= ~w_next_state[0];
      r_level    <= state_level(w_next_state);
    end
  end

  // Payload registers. When main drains to EMPTY its data is left in place
  // (invalid); only a flush with FLUSH_CLEARS_DATA zeroes it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_main_data <= '0;
      r_skid_data <= '0;
    end else if (i_flush) begin
      if (FLUSH_CLEARS_DATA) begin
        r_main_data <= '0;
        r_skid_data <= '0;
      end
    end else begin
      if (w_load_main_in) begin
        r_main_data <= i_in_data;
      end else if (w_load_main_skid) begin
        r_main_data <= r_skid_data;
      end
      if (w_load_skid) begin
        r_skid_data <= i_in_data;
      end
    end
  end

  // A held cycle is one where a valid payload could not leave; flush
  // cycles are excluded.
  pipe_sat_counter #(
    .CNT_W (CNT_W)
  ) u_hold_counter (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_inc   (w_main_valid & w_hold & ~i_flush),
    .o_count (o_hold_cycles)
  );

  assign o_in_ready  = r_in_ready;
  assign o_out_valid = w_main_valid;
  assign o_out_data  = r_main_data;
  assign o_level     = r_level;

endmodule
